// File: rtl/wb_port_arb_pkg.sv
// Shared types for the register-file write-port arbiter: widths, the
// write-port record and the port-source encoding.
package wb_port_arb_pkg;

  localparam int REG_AW = 5;
  localparam int XLEN   = 32;

  typedef struct packed {
    logic              we;
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wp_rec_t;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_PIPE = 2'd1,
    SRC_MDU  = 2'd2
  } src_e;

endpackage

// File: rtl/wb_port_arb_if.sv
// Bus bundle between the WR stage / MDU / register file and the arbiter.
// master = the surrounding pipeline side, slave = the arbiter.
interface wb_port_arb_if #(
  parameter int DEPTH = 2
) ();
  import wb_port_arb_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;

  logic              WRRWE;
  logic [REG_AW-1:0] WRrd;
  logic [XLEN-1:0]   RegData;
  logic              MDValid;
  logic [REG_AW-1:0] MDrd;
  logic [XLEN-1:0]   MDData;
  logic              MDReady;
  logic              MDIssue;
  logic [REG_AW-1:0] MDIssueRd;
  logic              RFWE;
  logic [REG_AW-1:0] RFrd;
  logic [XLEN-1:0]   RFData;
  logic              StallReq;
  logic [CW-1:0]     Pending;
  logic [31:0]       Busy;

  modport master (
    output WRRWE, WRrd, RegData, MDValid, MDrd, MDData, MDIssue, MDIssueRd,
    input  MDReady, RFWE, RFrd, RFData, StallReq, Pending, Busy
  );

  modport slave (
    input  WRRWE, WRrd, RegData, MDValid, MDrd, MDData, MDIssue, MDIssueRd,
    output MDReady, RFWE, RFrd, RFData, StallReq, Pending, Busy
  );

endinterface

// File: rtl/wb_port_arb_fifo.sv
// Small synchronous FIFO holding MDU results; DEPTH must be a power of two
// so the pointers wrap for free.
module wb_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 8
) (
  input  logic                       CLK,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [W-1:0]               din_i,
  output logic [W-1:0]               head_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_q];
  assign count_o = cnt_q;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (do_push) wr_d = wr_q + AW'(1);
    if (do_pop)  rd_d = rd_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge CLK) begin
    if (do_push) mem_q[wr_q] <= din_i;
  end

endmodule

// File: rtl/wb_port_arb.sv
// Register-file write-port arbiter: pipeline writeback first, buffered MDU
// results on idle cycles, with a starvation stall request. The per-register
// pending-write scoreboard is built only when WB_SCOREBOARD_EN is defined.
module wb_port_arb
  import wb_port_arb_pkg::*;
#(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          CLK,
  input  logic          rst_n,
  wb_port_arb_if.slave  bus
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int W  = REG_AW + XLEN;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] SLIM = SW'(STARVE_LIMIT);

  logic              preq;
  logic              push, pop;
  logic [W-1:0]      head;
  logic [REG_AW-1:0] head_rd;
  logic [XLEN-1:0]   head_data;
  logic [CW-1:0]     count;
  logic              full, empty;
  src_e              src;
  wp_rec_t           wp;
  logic [SW-1:0]     starve_q, starve_d;
  logic              stall_q, stall_d;

  assign preq = bus.WRRWE && (bus.WRrd != '0);

  // Outputs are forced quiet while reset is held, even if WRRWE is driven.
  assign bus.MDReady = rst_n && !full;
  assign push        = bus.MDValid && bus.MDReady;
  assign pop         = !preq && !empty;

  wb_fifo #(.DEPTH(DEPTH), .W(W)) u_fifo (
    .CLK     (CLK),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   ({bus.MDrd, bus.MDData}),
    .head_o  (head),
    .count_o (count),
    .full_o  (full),
    .empty_o (empty)
  );

  assign head_rd   = head[XLEN +: REG_AW];
  assign head_data = head[XLEN-1:0];

  always_comb begin
    src = SRC_NONE;
    if (preq)        src = SRC_PIPE;
    else if (!empty) src = SRC_MDU;
  end

  // An rd = 0 MDU entry still pops but never raises the write enable.
  always_comb begin
    wp = '0;
    case (src)
      SRC_PIPE: wp = '{we: 1'b1, rd: bus.WRrd, data: bus.RegData};
      SRC_MDU:  if (head_rd != '0) wp = '{we: 1'b1, rd: head_rd, data: head_data};
      default:  wp = '0;
    endcase
  end

  assign bus.RFWE    = rst_n && wp.we;
  assign bus.RFrd    = wp.rd;
  assign bus.RFData  = wp.data;
  assign bus.Pending = count;

  // Remaining-budget down-counter: reaching zero means STARVE_LIMIT blocked cycles.
  always_comb begin
    starve_d = starve_q;
    if (empty || pop)         starve_d = SLIM;
    else if (starve_q != '0)  starve_d = starve_q - SW'(1);
    stall_d = (starve_d == '0);
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      starve_q <= SLIM;
      stall_q  <= 1'b0;
    end else begin
      starve_q <= starve_d;
      stall_q  <= stall_d;
    end
  end

  assign bus.StallReq = stall_q;

`ifdef WB_SCOREBOARD_EN
  logic [31:0] busy_q, busy_d;

  // Issue is applied after retire so a same-cycle set wins.
  always_comb begin
    busy_d = busy_q;
    if (pop && head_rd != '0)                  busy_d[head_rd]       = 1'b0;
    if (bus.MDIssue && bus.MDIssueRd != '0)    busy_d[bus.MDIssueRd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  assign bus.Busy = busy_q;
`else
  assign bus.Busy = '0;
`endif

endmodule
